// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the MEM-stage load/store
// interface. It accepts one request at a time, inserts LATENCY wait states,
// performs the access on the edge entering RESP and pulses Ready for one cycle.
// Mem_Stall freezes the upstream pipeline while an access is outstanding.
module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Ready,
    output logic        Mem_Stall,
    output logic        Addr_Error
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;

    // Request captured at acceptance; used for the whole WAIT period.
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_rd;
    logic        lat_wr;

    logic [31:0] mem [DEPTH];

    logic                  request;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_data;
    logic                  acc_rd;
    logic                  acc_wr;
    logic                  acc_bad;
    logic [ADDR_WIDTH-1:0] acc_index;
    logic                  go_resp;

    // A request is illegal when both ops are set, the byte address is not
    // word aligned, or it lies beyond the last implemented word.
    function automatic logic is_illegal(input logic        rd,
                                        input logic        wr,
                                        input logic [31:0] addr);
        logic [31:0] upper;
        upper = addr >> (ADDR_WIDTH + 2);
        return (rd && wr) || (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

    assign request = MemRead | MemWrite;

    // Stall is raised combinationally in the request cycle so the pipeline
    // never advances past an unaccepted access; RESP releases it.
    always_comb begin
        Mem_Stall = 1'b0;
        case (state)
            IDLE:    Mem_Stall = request;
            WAIT:    Mem_Stall = 1'b1;
            default: Mem_Stall = 1'b0;
        endcase
    end

    // Select the operands of the access happening on this edge: live inputs
    // when a zero-latency request goes straight from IDLE, latched otherwise.
    always_comb begin
        acc_addr = lat_addr;
        acc_data = lat_data;
        acc_rd   = lat_rd;
        acc_wr   = lat_wr;
        go_resp  = 1'b0;
        if (state == IDLE) begin
            acc_addr = Address;
            acc_data = Write_data;
            acc_rd   = MemRead;
            acc_wr   = MemWrite;
            go_resp  = request && (LATENCY == 0);
        end else if (state == WAIT) begin
            go_resp  = (count == 4'd1);
        end
        acc_bad   = is_illegal(acc_rd, acc_wr, acc_addr);
        acc_index = acc_addr[ADDR_WIDTH+1:2];
    end

    // Control FSM, request latch, registered response outputs and storage.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            count      <= 4'd0;
            lat_addr   <= 32'd0;
            lat_data   <= 32'd0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            Read_data  <= 32'd0;
            Ready      <= 1'b0;
            Addr_Error <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            Ready      <= 1'b0;
            Addr_Error <= 1'b0;

            case (state)
                IDLE: begin
                    if (request) begin
                        lat_addr <= Address;
                        lat_data <= Write_data;
                        lat_rd   <= MemRead;
                        lat_wr   <= MemWrite;
                        count    <= LAT;
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // A request still held here belongs to the completed
                    // access; the next one is sampled back in IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // The memory access itself happens on the edge entering RESP.
            if (go_resp) begin
                Ready      <= 1'b1;
                Addr_Error <= acc_bad;
                if (acc_bad) begin
                    Read_data <= 32'd0;
                end else if (acc_rd) begin
                    Read_data <= mem[acc_index];
                end else if (acc_wr) begin
                    mem[acc_index] <= acc_data;
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the pipelined CPU's MEM-stage load/store interface.
- Accepts one MemRead/MemWrite request at a time and inserts a programmable number of wait states.
- Returns read data with a one-cycle Ready pulse.
- Drives Mem_Stall, which the hazard detection unit uses to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.

Parameters:
- ADDR_WIDTH, 8: word-index bits; depth = 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: wait cycles inserted between request acceptance and response; legal range 0..15.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- RST, input, 1: synchronous, active-low reset.
- MemRead, input, 1: load request from the EX/MEM register.
- MemWrite, input, 1: store request from the EX/MEM register.
- Address, input, 32: byte address (EX/MEM ALU result).
- Write_data, input, 32: store data (EX/MEM read data 2).
- Read_data, output, 32: load data; valid while Ready=1, then held.
- Ready, output, 1: one-cycle completion pulse for every accepted request.
- Mem_Stall, output, 1: pipeline freeze request to the hazard detection unit.
- Addr_Error, output, 1: one-cycle pulse, coincident with Ready, when the completed request was illegal.

Behaviour:
- Reset (RST=0 sampled at a rising edge):
  - FSM goes to IDLE.
  - Read_data, Ready, Addr_Error and Mem_Stall = 0.
  - All memory words cleared to 0.
  - Wait counter cleared.
  - Reset during WAIT or RESP aborts the access; a pending write is not committed.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - Request = MemRead | MemWrite.
  - Mem_Stall = request (combinational), so the stall is asserted in the same cycle the request appears.
  - On an edge with a request: latch Address, Write_data and op; load counter = LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
- WAIT:
  - Mem_Stall = 1.
  - Counter decrements each cycle; when counter == 1, next state is RESP.
  - Inputs are ignored; the latched copy is used.
- Transition into RESP: the access is performed at the edge entering RESP.
  - Read: Read_data <= mem[addr[ADDR_WIDTH+1:2]].
  - Write: mem[index] <= latched data; Read_data unchanged.
- RESP:
  - Ready = 1, Mem_Stall = 0. This lets the pipeline advance at the end of this cycle.
  - Next state is always IDLE. A request still present during RESP is not re-accepted.
  - A new request is first sampled in the following IDLE cycle.
- Latency: request present in cycle k while in IDLE gives Ready in cycle k+1+LATENCY. Mem_Stall is high in cycles k .. k+LATENCY.
- Illegal request conditions (checked on latched values):
  - MemRead and MemWrite both set.
  - Address[1:0] != 0 (misaligned).
  - Address[31:ADDR_WIDTH+2] != 0 (out of range).
- Illegal request handling:
  - Goes through the normal WAIT/RESP timing.
  - No memory write; Read_data <= 0.
  - Addr_Error = 1 in the RESP cycle.
- Read_data holds its value between completed reads and is unaffected by writes and IDLE cycles.
- A read of a word written by the immediately preceding request returns the new value.

Test Plan:
- Reset then idle: RST=0 for 2 cycles, then RST=1 with no requests. Required: Read_data=0, Ready=0, Mem_Stall=0, Addr_Error=0 throughout.
- Store then load, LATENCY=2:
  - MemWrite, Address=0x10, Write_data=0xDEADBEEF at cycle k. Required: Mem_Stall=1 in cycles k..k+2; Ready=1 in cycle k+3.
  - MemRead, Address=0x10 issued afterwards. Required: Read_data=0xDEADBEEF with Ready 3 cycles after the request appears.
- LATENCY=0: MemRead, Address=0x0 after reset. Required: Mem_Stall=1 for exactly one cycle, Ready the next cycle, Read_data=0.
- Misaligned and out-of-range (ADDR_WIDTH=8):
  - MemWrite to 0x12. Required: Ready and Addr_Error pulse; mem[4] unchanged.
  - MemRead to 0x400. Required: Read_data=0, Addr_Error=1.
  - MemRead and MemWrite together. Required: Addr_Error=1, no write.
- Back-to-back requests: request held high through RESP, then a new request.
  - Required: exactly one Ready per request.
  - Second request accepted only from the following IDLE cycle.
  - Mem_Stall=0 only in the RESP cycle.
- Reset mid-operation: MemWrite 0x20 = 0x12345678, RST=0 during WAIT.
  - Required: no Ready pulse; outputs return to 0.
  - A later read of 0x20 returns 0.
